mem_req_scheduler: RTL and testbench

Sequences all cacheline traffic onto the single cacheline adaptor. Three requesters compete: icache, dcache and a next-line instruction prefetcher. Policy is fixed priority (dcache > icache > prefetch) with a starvation guard for icache. A prefetch to the line icache is already fetching is merged rather than re-issued. Sits between the L1 caches/prefetcher and `cacheline_adaptor`, replacing the two-port arbiter in `mp4`.

---
 rtl/rv32i_types.sv | 26 ++
 rtl/mem_req_scheduler.sv | 159 +++++++++++++++
 tb/tb_mem_req_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the cacheline request scheduler.
// Holds scheduler state/owner encodings and line-address helpers.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        I,
        D,
        P
    } sched_owner_t;

    localparam int LINE_OFFSET_BITS = 5;

    localparam logic [31:0] LINE_MASK =
        ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & LINE_MASK;
    endfunction

endpackage

// File: rtl/mem_req_scheduler.sv
// Arbitrates icache, dcache and prefetch line traffic onto one adaptor.
// Fixed priority D > I > P with an icache starvation guard and I+P merge.
module mem_req_scheduler
    import rv32i_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         icache_read,
    input  logic [31:0]  icache_address,
    output logic         icache_resp,
    output logic [255:0] icache_rdata,

    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [31:0]  dcache_address,
    input  logic [255:0] dcache_wdata,
    output logic         dcache_resp,
    output logic [255:0] dcache_rdata,

    input  logic         pf_read,
    input  logic [31:0]  pf_address,
    output logic         pf_resp,
    output logic [255:0] pf_rdata,

    output logic         adapter_read,
    output logic         adapter_write,
    output logic [31:0]  adapter_address,
    output logic [255:0] adapter_wdata,
    input  logic         adapter_resp,
    input  logic [255:0] adapter_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    sched_state_t state;
    sched_state_t state_next;
    sched_owner_t owner;
    sched_owner_t owner_sel;

    logic [31:0]   addr_q;
    logic          write_q;
    logic [255:0]  wdata_q;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] cnt_next;

    logic          dcache_req;
    logic          any_req;
    logic          starved;
    logic          take;
    logic          grant_i;
    logic          grant_d;
    logic          grant_p;
    logic [31:0]   sel_addr;
    logic          serving;
    logic          fin;
    logic          merge;

    assign dcache_req = dcache_read | dcache_write;
    assign any_req    = dcache_req | icache_read | pf_read;
    assign starved    = (starve_cnt == CNT_MAX) && icache_read;
    assign take       = (state == IDLE) && any_req;

    // Grant selection; only consumed while IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        grant_p = 1'b0;
        priority case (1'b1)
            starved:     grant_i = 1'b1;
            dcache_req:  grant_d = 1'b1;
            icache_read: grant_i = 1'b1;
            pf_read:     grant_p = 1'b1;
            default:     ;
        endcase
    end

    always_comb begin
        owner_sel = P;
        sel_addr  = pf_address;
        if (grant_d) begin
            owner_sel = D;
            sel_addr  = dcache_address;
        end else if (grant_i) begin
            owner_sel = I;
            sel_addr  = icache_address;
        end
    end

    // Only a dcache win over a waiting icache counts toward starvation.
    always_comb begin
        cnt_next = '0;
        if (grant_d && icache_read) begin
            if (starve_cnt == CNT_MAX) begin
                cnt_next = starve_cnt;
            end else begin
                cnt_next = starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SERVE;
            SERVE:   if (adapter_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= I;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            starve_cnt <= '0;
        end else if (take) begin
            owner      <= owner_sel;
            addr_q     <= line_addr(sel_addr);
            write_q    <= grant_d & dcache_write;
            wdata_q    <= dcache_wdata;
            starve_cnt <= cnt_next;
        end
    end

    assign serving = (state == SERVE);
    assign fin     = serving & adapter_resp;
    assign merge   = (owner == I) && pf_read &&
                     (line_addr(pf_address) == addr_q);

    always_comb begin
        adapter_read    = serving & ~write_q;
        adapter_write   = serving & write_q;
        adapter_address = serving ? addr_q : '0;
        adapter_wdata   = serving ? wdata_q : '0;

        icache_resp  = fin && (owner == I);
        dcache_resp  = fin && (owner == D);
        pf_resp      = fin && ((owner == P) || merge);

        icache_rdata = icache_resp ? adapter_rdata : '0;
        dcache_rdata = dcache_resp ? adapter_rdata : '0;
        pf_rdata     = pf_resp ? adapter_rdata : '0;
    end

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Randomized scoreboard bench for mem_req_scheduler.
// A transaction-level model predicts adaptor traffic and completions.
module tb_mem_req_scheduler;

    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic         icache_resp;
    logic [255:0] icache_rdata;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic         dcache_resp;
    logic [255:0] dcache_rdata;
    logic         pf_read;
    logic [31:0]  pf_address;
    logic         pf_resp;
    logic [255:0] pf_rdata;
    logic         adapter_read;
    logic         adapter_write;
    logic [31:0]  adapter_address;
    logic [255:0] adapter_wdata;
    logic         adapter_resp;
    logic [255:0] adapter_rdata;

    mem_req_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .icache_read(icache_read),
        .icache_address(icache_address),
        .icache_resp(icache_resp),
        .icache_rdata(icache_rdata),
        .dcache_read(dcache_read),
        .dcache_write(dcache_write),
        .dcache_address(dcache_address),
        .dcache_wdata(dcache_wdata),
        .dcache_resp(dcache_resp),
        .dcache_rdata(dcache_rdata),
        .pf_read(pf_read),
        .pf_address(pf_address),
        .pf_resp(pf_resp),
        .pf_rdata(pf_rdata),
        .adapter_read(adapter_read),
        .adapter_write(adapter_write),
        .adapter_address(adapter_address),
        .adapter_wdata(adapter_wdata),
        .adapter_resp(adapter_resp),
        .adapter_rdata(adapter_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } adp_t;

    typedef struct {
        logic         i;
        logic         d;
        logic         p;
        logic [255:0] data;
    } rsp_t;

    adp_t q_adp[$];
    rsp_t q_rsp[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 2047));
    endfunction

    always @(negedge clk) begin
        if (!rst && dcache_read && dcache_write)
            $error("illegal dcache read+write");
    end

    // Monitor: one expected adaptor view and one expected completion per cycle.
    always @(negedge clk) begin
        adp_t ea;
        rsp_t er;
        logic bad;
        if (q_adp.size() > 0) begin
            ea = q_adp.pop_front();
            checks++;
            bad = ({adapter_read, adapter_write} != {ea.rd, ea.wr});
            if ((ea.rd || ea.wr) && adapter_address != ea.addr) bad = 1'b1;
            if (ea.wr && adapter_wdata != ea.wdata) bad = 1'b1;
            if (bad) begin
                failures++;
                $display("FAIL adapter t=%0t got rd=%0b wr=%0b a=%h exp rd=%0b wr=%0b a=%h",
                         $time, adapter_read, adapter_write, adapter_address,
                         ea.rd, ea.wr, ea.addr);
            end
        end
        if (q_rsp.size() > 0) begin
            er = q_rsp.pop_front();
            checks++;
            bad = ({icache_resp, dcache_resp, pf_resp} != {er.i, er.d, er.p});
            if (er.i && icache_rdata != er.data) bad = 1'b1;
            if (er.d && dcache_rdata != er.data) bad = 1'b1;
            if (er.p && pf_rdata != er.data) bad = 1'b1;
            if (bad) begin
                failures++;
                $display("FAIL resp t=%0t got i=%0b d=%0b p=%0b exp i=%0b d=%0b p=%0b",
                         $time, icache_resp, dcache_resp, pf_resp,
                         er.i, er.d, er.p);
            end
        end
    end

    int   m_state;
    int   m_owner;
    int   m_cnt;
    int   m_lat;
    logic [31:0]  m_addr;
    logic         m_wr;
    logic [255:0] m_wdata;
    rsp_t last_rsp;
    rsp_t er_now;
    adp_t ea_now;
    int   n_starve;
    int   n_merge;
    int   n_rst_mid;
    int   p_i;
    int   p_d;
    int   p_p;
    int   rst_en;

    initial begin
        rst = 1'b1;
        icache_read = 1'b0;
        icache_address = '0;
        dcache_read = 1'b0;
        dcache_write = 1'b0;
        dcache_address = '0;
        dcache_wdata = '0;
        pf_read = 1'b0;
        pf_address = '0;
        adapter_resp = 1'b0;
        adapter_rdata = '0;
        m_state = 0;
        m_owner = 0;
        m_cnt = 0;
        m_lat = 0;
        m_addr = '0;
        m_wr = 1'b0;
        m_wdata = '0;
        last_rsp = '{1'b0, 1'b0, 1'b0, 256'h0};
        n_starve = 0;
        n_merge = 0;
        n_rst_mid = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({adapter_read, adapter_write, icache_resp, dcache_resp, pf_resp} != 5'b0
            || adapter_address != 32'h0) begin
            failures++;
            $display("FAIL reset_state got rd=%0b wr=%0b a=%h exp all zero",
                     adapter_read, adapter_write, adapter_address);
        end

        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin p_i = 60;  p_d = 0;   p_p = 0;  rst_en = 0; end
                1: begin p_i = 100; p_d = 100; p_p = 0;  rst_en = 0; end
                2: begin p_i = 40;  p_d = 30;  p_p = 60; rst_en = 0; end
                3: begin p_i = 50;  p_d = 50;  p_p = 40; rst_en = 1; end
                default: begin p_i = 0; p_d = 0; p_p = 0; rst_en = 0; end
            endcase
            for (int c = 0; c < 600; c++) begin
                @(posedge clk);
                #1;
                // Advance the model by what the DUT saw at this edge.
                if (rst) begin
                    m_state = 0;
                    m_cnt = 0;
                end else if (m_state == 0) begin
                    if (icache_read || dcache_read || dcache_write || pf_read) begin
                        if (m_cnt == LIMIT && icache_read) begin
                            m_owner = 0;
                            if (dcache_read || dcache_write) n_starve++;
                        end else if (dcache_read || dcache_write) m_owner = 1;
                        else if (icache_read) m_owner = 0;
                        else m_owner = 2;
                        if (m_owner == 1 && icache_read) begin
                            if (m_cnt < LIMIT) m_cnt++;
                        end else begin
                            m_cnt = 0;
                        end
                        case (m_owner)
                            0: m_addr = {icache_address[31:5], 5'b0};
                            1: m_addr = {dcache_address[31:5], 5'b0};
                            default: m_addr = {pf_address[31:5], 5'b0};
                        endcase
                        m_wr = (m_owner == 1) && dcache_write;
                        m_wdata = dcache_wdata;
                        m_lat = $urandom_range(0, 7);
                        m_state = 1;
                    end
                end else if (m_state == 1) begin
                    if (adapter_resp) m_state = 2;
                end else begin
                    m_state = 0;
                end

                rst = (rst_en != 0) && ($urandom_range(0, 60) == 0);
                if (rst) begin
                    if (m_state == 1) n_rst_mid++;
                    icache_read = 1'b0;
                    dcache_read = 1'b0;
                    dcache_write = 1'b0;
                    pf_read = 1'b0;
                end else begin
                    if (last_rsp.i) icache_read = 1'b0;
                    else if (!icache_read) begin
                        if ($urandom_range(0, 99) < p_i) begin
                            icache_read = 1'b1;
                            icache_address = rand_addr();
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        icache_address = rand_addr();
                    end

                    if (last_rsp.d) begin
                        dcache_read = 1'b0;
                        dcache_write = 1'b0;
                    end else if (!(dcache_read || dcache_write)) begin
                        if ($urandom_range(0, 99) < p_d) begin
                            dcache_write = ($urandom_range(0, 1) == 1);
                            dcache_read = !dcache_write;
                            dcache_address = rand_addr();
                            dcache_wdata = rand256();
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        dcache_address = rand_addr();
                        dcache_wdata = rand256();
                    end

                    if (last_rsp.p) pf_read = 1'b0;
                    else if (!pf_read && $urandom_range(0, 99) < p_p) begin
                        pf_read = 1'b1;
                        if ($urandom_range(0, 1) == 1)
                            pf_address = {icache_address[31:5], 5'($urandom_range(0, 31))};
                        else
                            pf_address = rand_addr();
                    end
                end

                adapter_resp = 1'b0;
                adapter_rdata = rand256();
                er_now = '{1'b0, 1'b0, 1'b0, 256'h0};
                if (!rst && m_state == 1) begin
                    if (m_lat == 0) begin
                        adapter_resp = 1'b1;
                        er_now.data = adapter_rdata;
                        er_now.i = (m_owner == 0);
                        er_now.d = (m_owner == 1);
                        er_now.p = (m_owner == 2) ||
                                   (m_owner == 0 && pf_read &&
                                    pf_address[31:5] == m_addr[31:5]);
                        if (m_owner == 0 && er_now.p) n_merge++;
                    end else begin
                        m_lat--;
                    end
                end
                last_rsp = rst ? '{1'b0, 1'b0, 1'b0, 256'h0} : er_now;

                ea_now.rd = (m_state == 1) && !m_wr;
                ea_now.wr = (m_state == 1) && m_wr;
                ea_now.addr = m_addr;
                ea_now.wdata = m_wdata;
                q_adp.push_back(ea_now);
                q_rsp.push_back(er_now);
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (n_starve == 0) begin
            failures++;
            $display("FAIL cov_starve got %0d exp >0", n_starve);
        end
        checks++;
        if (n_merge == 0) begin
            failures++;
            $display("FAIL cov_merge got %0d exp >0", n_merge);
        end
        checks++;
        if (n_rst_mid == 0) begin
            failures++;
            $display("FAIL cov_rst_mid got %0d exp >0", n_rst_mid);
        end
        checks++;
        if (q_adp.size() != 0 || q_rsp.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d/%0d exp 0/0", q_adp.size(), q_rsp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
